// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: accepts a ROM image from the loader, forwards bytes to the
// core, checks size/range, and sequences core reset around the load.
//
// Ports:
//   clk_sys        in   system clock, rising edge
//   reset_n        in   async active-low reset
//   ioctl_download in   loader session active
//   ioctl_wr       in   one-cycle byte strobe
//   ioctl_addr     in   [24:0] byte address
//   ioctl_dout     in   [7:0] byte data
//   user_reset     in   OSD reset OR reset button
//   dn_addr        out  [15:0] ROM write address to core
//   dn_data        out  [7:0] ROM write data to core
//   dn_wr          out  ROM write strobe to core (1-cycle latency)
//   core_reset     out  active-high core reset, low only in RUN
//   load_done      out  valid image loaded, core running
//   load_err       out  last session invalid (latched until next load)
//   checksum       out  [7:0] mod-256 sum of accepted bytes of last session
module rom_load_ctrl #(
    parameter logic [16:0] ROM_SIZE    = 17'h10000,
    parameter int unsigned HOLD_CYCLES = 64
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        ERR
    } state_t;

    localparam logic [24:0] ADDR_LIM  = {8'd0, ROM_SIZE};
    localparam logic [16:0] CNT_MAX   = 17'h10000;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_dl_q;
    logic [16:0] r_count;
    logic        r_drop;
    logic [7:0]  r_checksum;
    logic [15:0] r_hold_cnt;
    logic [15:0] r_dn_addr;
    logic [7:0]  r_dn_data;
    logic        r_dn_wr;

    logic        w_dl_rise;
    logic        w_dl_fall;
    logic        w_in_range;
    logic        w_accept;
    logic        w_reject;
    logic [16:0] w_count_nx;
    logic        w_drop_nx;
    logic        w_load_entry;
    logic        w_hold_stay;

    // Inputs are clk_sys-synchronous; one register is enough for edges.
    assign w_dl_rise  = ioctl_download & ~r_dl_q;
    assign w_dl_fall  = ~ioctl_download & r_dl_q;

    assign w_in_range = (ioctl_addr < ADDR_LIM);
    assign w_accept   = (r_state == LOAD) & ioctl_wr & w_in_range;
    assign w_reject   = (r_state == LOAD) & ioctl_wr & ~w_in_range;

    // Next-cycle count/drop, so a strobe on the falling edge is
    // included in the completion compare.
    always_comb begin
        w_count_nx = r_count;
        if (w_accept && (r_count != CNT_MAX)) begin
            w_count_nx = r_count + 17'd1;
        end
    end

    assign w_drop_nx = r_drop | w_reject;

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: begin
                if (ioctl_download) begin
                    w_state_nx = LOAD;
                end
            end
            LOAD: begin
                if (w_dl_fall) begin
                    if ((w_count_nx == ROM_SIZE) && !w_drop_nx) begin
                        w_state_nx = HOLD;
                    end else begin
                        w_state_nx = ERR;
                    end
                end
            end
            HOLD: begin
                if (!user_reset && (r_hold_cnt == HOLD_LAST)) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (user_reset) begin
                    w_state_nx = HOLD;
                end
            end
            ERR: begin
                w_state_nx = ERR;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        if (w_dl_rise) begin
            w_state_nx = LOAD;
        end
    end

    assign w_load_entry = (w_state_nx == LOAD) && (r_state != LOAD);
    assign w_hold_stay  = (r_state == HOLD) && (w_state_nx == HOLD);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_dl_q  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_dl_q  <= ioctl_download;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_drop     <= 1'b0;
            r_checksum <= '0;
        end else if (w_load_entry) begin
            r_count    <= '0;
            r_drop     <= 1'b0;
            r_checksum <= '0;
        end else if (r_state == LOAD) begin
            r_count <= w_count_nx;
            r_drop  <= w_drop_nx;
            if (w_accept) begin
                r_checksum <= r_checksum + ioctl_dout;
            end
        end
    end

    // user_reset pins the count at 0, so HOLD lasts HOLD_CYCLES
    // after it drops.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
        end else if (w_hold_stay && !user_reset) begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
        end else begin
            r_hold_cnt <= '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dn_addr <= '0;
            r_dn_data <= '0;
            r_dn_wr   <= 1'b0;
        end else begin
            r_dn_wr <= w_accept;
            if (w_accept) begin
                r_dn_addr <= ioctl_addr[15:0];
                r_dn_data <= ioctl_dout;
            end
        end
    end

    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign dn_wr      = r_dn_wr;
    assign core_reset = (r_state != RUN);
    assign load_done  = (r_state == RUN);
    assign load_err   = (r_state == ERR);
    assign checksum   = r_checksum;

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 17'h10000, meaning the byte count for a valid image; legal range 1..65536.
REQ-002 SHALL have parameter HOLD_CYCLES, default 64, meaning the post-load core reset stretch in clk_sys cycles; legal range 1..65535.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ioctl_download, input, 1 bit: the loader session is active.
REQ-006 SHALL have port ioctl_wr, input, 1 bit: a one-cycle byte strobe.
REQ-007 SHALL have port ioctl_addr, input, 25 bits: the byte address.
REQ-008 SHALL have port ioctl_dout, input, 8 bits: the byte data.
REQ-009 SHALL have port user_reset, input, 1 bit: an OR of the OSD reset and the reset button.
REQ-010 SHALL have port dn_addr, output, 16 bits: the ROM write address to the core.
REQ-011 SHALL have port dn_data, output, 8 bits: the ROM write data to the core.
REQ-012 SHALL have port dn_wr, output, 1 bit: the ROM write strobe to the core.
REQ-013 SHALL have port core_reset, output, 1 bit, active-high: the core reset.
REQ-014 SHALL have port load_done, output, 1 bit: a valid image is loaded and the core is running.
REQ-015 SHALL have port load_err, output, 1 bit: the last session was invalid.
REQ-016 SHALL have port checksum, output, 8 bits: the modulo-256 sum of the accepted bytes in the last session.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, HOLD, RUN and ERR.
REQ-018 SHALL make the state transitions as follows.
- IDLE->LOAD on ioctl_download=1.
- LOAD->HOLD on ioctl_download falling edge with byte count == ROM_SIZE and no dropped byte.
- LOAD->ERR on ioctl_download falling edge otherwise.
- HOLD->RUN when the hold counter reaches HOLD_CYCLES-1.
- RUN->HOLD on user_reset=1.
- Any state->LOAD on ioctl_download rising edge.
REQ-019 SHALL, on LOAD entry, clear the byte count, checksum, dropped flag, load_done and load_err in the same cycle.
REQ-020 SHALL, in LOAD with ioctl_wr=1 and ioctl_addr < ROM_SIZE, register ioctl_addr[15:0] onto dn_addr and ioctl_dout onto dn_data, and pulse dn_wr for exactly one cycle, one cycle after the strobe (latency 1).
REQ-021 SHALL, in LOAD with ioctl_wr=1 and ioctl_addr >= ROM_SIZE, suppress dn_wr, set the dropped flag, and leave the checksum and count unchanged.
REQ-022 SHALL, for each accepted byte, increment the byte count (17-bit, saturating at 65536) and add ioctl_dout to the checksum with wrap-around modulo 256.
REQ-023 SHALL ignore ioctl_wr outside LOAD, keeping dn_wr=0.
REQ-024 SHALL count a strobe coincident with the ioctl_download falling edge before the completion compare.
REQ-025 SHALL drive core_reset=1 in IDLE, LOAD, HOLD and ERR, and core_reset=0 only in RUN.
REQ-026 SHALL assert load_done=1 only in RUN.
REQ-027 SHALL assert load_err=1 only in ERR, where it stays latched until the next LOAD entry.
REQ-028 SHALL ignore user_reset in ERR; only a new download exits ERR.
REQ-029 SHALL restart the hold count from 0 while user_reset=1 in HOLD; HOLD exits HOLD_CYCLES cycles after user_reset deasserts.
REQ-030 SHALL keep checksum stable after LOAD exit until the next LOAD entry.
REQ-031 SHALL sample ioctl_download through a single register for edge detection and SHALL NOT add synchronizers, because all inputs are clk_sys-synchronous.

Reset
REQ-032 SHALL, while reset_n=0, immediately force the following values.
- state=IDLE
- dn_addr=0, dn_data=0, dn_wr=0
- core_reset=1
- load_done=0, load_err=0
- checksum=0
- counters=0
REQ-033 SHALL, on reset_n asserted mid-LOAD or mid-HOLD, abandon the session; after release the block waits in IDLE for a new download.
REQ-034 SHALL release reset_n synchronously to clk_sys and make no state change on the release edge.

Verification
REQ-035 SHALL verify a clean load: ROM_SIZE=4, HOLD_CYCLES=3, bytes 0x10,0x20,0x30,0x40 at addresses 0..3, then download falls.
- Required response: 4 dn_wr pulses, each 1 cycle after its strobe, with matching dn_addr/dn_data.
- Required response: checksum=0xA0.
- Required response: core_reset falls 3 cycles after HOLD entry; load_done=1.
REQ-036 SHALL verify a short load: ROM_SIZE=4, 3 bytes, then download falls.
- Required response: ERR, load_err=1, core_reset stays 1.
- Required response: user_reset pulses have no effect.
REQ-037 SHALL verify an out-of-range byte: ROM_SIZE=4, 5 strobes at addresses 0..4.
- Required response: no dn_wr for address 4.
- Required response: ERR at end, checksum excludes the 5th byte.
REQ-038 SHALL verify user reset in RUN: user_reset held 5 cycles.
- Required response: core_reset=1 immediately.
- Required response: core_reset returns to 0 exactly HOLD_CYCLES cycles after user_reset drops.
REQ-039 SHALL verify reset mid-load: reset_n=0 after 2 of 4 bytes.
- Required response: all outputs at reset values immediately.
- Required response: a new full download then reaches RUN.
REQ-040 SHALL verify a checksum wrap: bytes 0xFF,0x02.
- Required response: checksum=0x01.
